// File: rtl/nota_pkg.sv
// Shared codes for the note-phrase sequencer: note/tipo encodings, FSM states
// and the stored autoplay phrases.
package nota_pkg;

  localparam int unsigned TAB_LEN = 6;
  localparam int unsigned ROW_W   = $clog2(TAB_LEN);

  typedef enum logic [2:0] {
    NOTA_X, NOTA_DO, NOTA_RE, NOTA_MI, NOTA_FA, NOTA_SOL, NOTA_LA, NOTA_SI
  } nota_e;

  typedef enum logic [1:0] {
    TIPO_NULO, TIPO_ADJ, TIPO_COMP, TIPO_ADV
  } tipo_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ISSUE, S_GAP, S_WAIT_FIM, S_DONE
  } state_e;

  // {tom, nota}
  typedef logic [3:0] entry_t;

  // A phrase ends at the first NOTA_X entry, or at the last column otherwise.
  localparam entry_t TABELA [4][TAB_LEN] = '{
    '{{1'b0, NOTA_DO}, {1'b0, NOTA_LA}, {1'b0, NOTA_SI},
      {1'b0, NOTA_X},  {1'b0, NOTA_X},  {1'b0, NOTA_X}},
    '{{1'b1, NOTA_RE}, {1'b0, NOTA_MI}, {1'b1, NOTA_FA},
      {1'b0, NOTA_SOL}, {1'b1, NOTA_LA}, {1'b0, NOTA_SI}},
    '{{1'b0, NOTA_MI}, {1'b0, NOTA_X},  {1'b0, NOTA_X},
      {1'b0, NOTA_X},  {1'b0, NOTA_X},  {1'b0, NOTA_X}},
    '{{1'b1, NOTA_DO}, {1'b1, NOTA_RE}, {1'b0, NOTA_X},
      {1'b0, NOTA_X},  {1'b0, NOTA_X},  {1'b0, NOTA_X}}
  };

endpackage

// File: rtl/nota_seq_ctrl_if.sv
// Classifier-side handshake: the sequencer drives entries and the classifier
// reset, the classifier answers with fim/tipo.
interface nota_seq_ctrl_if;
  logic       ok_out;
  logic       tom_out;
  logic [2:0] nota_out;
  logic       rst_rec;
  logic       fim_in;
  logic [1:0] tipo_in;

  modport master (output ok_out, tom_out, nota_out, rst_rec, input fim_in, tipo_in);
  modport slave  (input ok_out, tom_out, nota_out, rst_rec, output fim_in, tipo_in);
endinterface

// File: rtl/nota_frase_rom.sv
// Combinational lookup of one stored phrase entry; indices past the table
// read as NOTA_X so the phrase terminates there.
module nota_frase_rom
  import nota_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic [1:0]       sel,
  input  logic [IDX_W-1:0] idx,
  output entry_t           entry
);

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < TAB_LEN; i++) begin
      if (32'(idx) == i) entry = TABELA[sel][i[ROW_W-1:0]];
    end
  end

endmodule

// File: rtl/nota_seq_ctrl.sv
// Sequencer/arbiter feeding the note-phrase classifier either from keypad
// entry or from autoplay of stored phrases; latches and counts results.
module nota_seq_ctrl
  import nota_pkg::*;
#(
  parameter int unsigned MAX_LEN = TAB_LEN,
  parameter int unsigned GAP     = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            modo,
  input  logic            start,
  input  logic [1:0]      sel_frase,
  input  logic            man_ok,
  input  logic            man_tom,
  input  logic [2:0]      man_nota,
  nota_seq_ctrl_if.master cls,
  output logic            busy,
  output logic            done,
  output logic [1:0]      tipo_out,
  output logic            erro_timeout,
  output logic [3:0]      cont_frases
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GAP_W = $clog2(GAP + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  // WAIT_FIM starts one cycle after the terminal ok_out, which already counts
  // towards the timeout, so DONE lands exactly TIMEOUT cycles after it.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             man_ok_prev_q, man_ok_prev_d;
  logic             ok_q, ok_d;
  logic             tom_q, tom_d;
  logic [2:0]       nota_q, nota_d;
  logic             rst_rec_q, rst_rec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       tipo_q, tipo_d;
  logic             erro_q, erro_d;
  logic [3:0]       cont_q, cont_d;
  logic             finish, timed_out;
  entry_t           rom_entry;

  nota_frase_rom #(.IDX_W(IDX_W)) u_rom (
    .sel   (sel_q),
    .idx   (idx_q),
    .entry (rom_entry)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    tmo_d         = tmo_q;
    man_ok_prev_d = man_ok;
    ok_d          = 1'b0;
    rst_rec_d     = 1'b0;
    done_d        = 1'b0;
    tom_d         = tom_q;
    nota_d        = nota_q;
    tipo_d        = tipo_q;
    erro_d        = erro_q;
    cont_d        = cont_q;
    finish        = 1'b0;
    timed_out     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (modo && start) begin
          sel_d     = sel_frase;
          idx_d     = '0;
          erro_d    = 1'b0;
          rst_rec_d = 1'b1;
          state_d   = S_CLR;
        end else begin
          if (!modo && man_ok && !man_ok_prev_q) begin
            ok_d   = 1'b1;
            tom_d  = man_tom;
            nota_d = man_nota;
          end
          finish = cls.fim_in;
        end
      end
      S_CLR: begin
        ok_d    = 1'b1;
        tom_d   = rom_entry[3];
        nota_d  = rom_entry[2:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cls.fim_in) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else if (rom_entry[2:0] == NOTA_X || idx_q == IDX_LAST) begin
          tmo_d   = '0;
          state_d = S_WAIT_FIM;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cls.fim_in) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          ok_d    = 1'b1;
          tom_d   = rom_entry[3];
          nota_d  = rom_entry[2:0];
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_WAIT_FIM: begin
        if (cls.fim_in) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result is latched on the edge that raises done, so tipo_out is valid with it.
    if (finish) begin
      done_d = 1'b1;
      tipo_d = timed_out ? TIPO_NULO : cls.tipo_in;
      if (timed_out) begin
        erro_d = 1'b1;
      end else if (cont_q != 4'hF) begin
        cont_d = cont_q + 4'd1;
      end
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      man_ok_prev_q <= 1'b0;
      ok_q          <= 1'b0;
      tom_q         <= 1'b0;
      nota_q        <= '0;
      rst_rec_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tipo_q        <= '0;
      erro_q        <= 1'b0;
      cont_q        <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      man_ok_prev_q <= man_ok_prev_d;
      ok_q          <= ok_d;
      tom_q         <= tom_d;
      nota_q        <= nota_d;
      rst_rec_q     <= rst_rec_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tipo_q        <= tipo_d;
      erro_q        <= erro_d;
      cont_q        <= cont_d;
    end
  end

  assign cls.ok_out   = ok_q;
  assign cls.tom_out  = tom_q;
  assign cls.nota_out = nota_q;
  assign cls.rst_rec  = rst_rec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tipo_out     = tipo_q;
  assign erro_timeout = erro_q;
  assign cont_frases  = cont_q;

endmodule

// File: tb/tb_nota_seq_ctrl.sv
// Scoreboard bench for nota_seq_ctrl: stimulus pushes expected pulse events
// (cycle + payload), a negedge monitor pops and compares them.
module tb_nota_seq_ctrl;

  localparam int GAP_C = 4;
  localparam int TMO_C = 16;
  localparam logic [1:0] EV_RST  = 2'd0;
  localparam logic [1:0] EV_OK   = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  logic       clk = 1'b0;
  logic       reset, modo, start, man_ok, man_tom;
  logic [1:0] sel_frase;
  logic [2:0] man_nota;
  logic       busy, done, erro_timeout;
  logic [1:0] tipo_out;
  logic [3:0] cont_frases;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   exp_cont = 0;
  logic exp_erro = 1'b0;

  typedef struct packed {
    logic [1:0] kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  nota_seq_ctrl_if cls();

  nota_seq_ctrl #(.MAX_LEN(6), .GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
    .clk          (clk),
    .reset        (reset),
    .modo         (modo),
    .start        (start),
    .sel_frase    (sel_frase),
    .man_ok       (man_ok),
    .man_tom      (man_tom),
    .man_nota     (man_nota),
    .cls          (cls),
    .busy         (busy),
    .done         (done),
    .tipo_out     (tipo_out),
    .erro_timeout (erro_timeout),
    .cont_frases  (cont_frases)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input logic [1:0] kind, input int at, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_ev(input logic [1:0] kind, input logic [7:0] data, input string name);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected pulse at cyc %0d data=%h, expected none", name, cyc, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.cyc != cyc || e.data !== data) begin
        bad++;
        $display("FAIL %s: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h",
                 name, kind, cyc, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cls.rst_rec === 1'b1) check_ev(EV_RST, 8'h00, "rst_rec");
    if (cls.ok_out === 1'b1)  check_ev(EV_OK, {4'h0, cls.tom_out, cls.nota_out}, "ok_out");
    if (done === 1'b1)        check_ev(EV_DONE, {1'b0, erro_timeout, cont_frases, tipo_out}, "done");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {17'h0, cls.ok_out, cls.tom_out, cls.nota_out, cls.rst_rec, busy, done,
              tipo_out, erro_timeout, cont_frases}, 32'h0);
  endtask

  // fim_at: offset from the start cycle at which fim_in is present; <0 means never.
  task automatic autoplay(input logic [1:0] sel, input int n_ok, input logic [23:0] ents,
                          input int fim_at, input logic [1:0] tipo, input bit disturb);
    int b, last, done_at;
    bit tout;
    b       = cyc;
    last    = b + 2 + (GAP_C + 1) * (n_ok - 1);
    tout    = (fim_at < 0);
    done_at = tout ? last + TMO_C : b + fim_at + 1;
    exp_erro = tout;
    if (!tout && exp_cont < 15) exp_cont++;
    modo = 1'b1; start = 1'b1; sel_frase = sel;
    push(EV_RST, b + 1, 8'h00);
    for (int i = 0; i < n_ok; i++) push(EV_OK, b + 2 + (GAP_C + 1) * i, {4'h0, ents[4*i +: 4]});
    push(EV_DONE, done_at, {1'b0, exp_erro, 4'(exp_cont), tout ? 2'b00 : tipo});
    step(1);
    start = 1'b0;
    while (cyc <= done_at) begin
      cls.fim_in  = (!tout && cyc == b + fim_at);
      cls.tipo_in = tipo;
      if (disturb && cyc < done_at - 1) begin
        modo = cyc[0]; man_ok = cyc[1]; sel_frase = ~sel;
      end else begin
        modo = 1'b1; man_ok = 1'b0; sel_frase = sel;
      end
      chk("busy", busy, cyc < done_at);
      step(1);
    end
    cls.fim_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cyc=%0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset = 1'b1; modo = 1'b0; start = 1'b0; sel_frase = '0;
    man_ok = 1'b0; man_tom = 1'b0; man_nota = '0;
    cls.fim_in = 1'b0; cls.tipo_in = '0;
    step(3);
    check_zero("reset_state");
    reset = 1'b0;
    step(1);

    // phrase 0 with fim two cycles after the terminal entry
    autoplay(2'd0, 4, 24'h000761, 19, 2'b01, 1'b0);
    // same phrase, fim never arrives
    autoplay(2'd0, 4, 24'h000761, -1, 2'b01, 1'b0);
    chk("erro_timeout_held", erro_timeout, 32'd1);
    chk("tipo_after_timeout", tipo_out, 32'd0);

    // manual entry: one pulse per rising edge, no rst_rec
    modo = 1'b0; man_tom = 1'b0; man_nota = 3'b110; man_ok = 1'b1;
    push(EV_OK, cyc + 1, 8'h06);
    step(5);
    man_ok = 1'b0; man_tom = 1'b1; man_nota = 3'b001;
    step(2);
    chk("nota_hold", {cls.tom_out, cls.nota_out}, 32'h6);
    man_ok = 1'b1;
    push(EV_OK, cyc + 1, 8'h09);
    step(2);
    man_ok = 1'b0;
    step(2);
    cls.fim_in = 1'b1; cls.tipo_in = 2'b11;
    exp_cont++;
    push(EV_DONE, cyc + 1, {1'b0, exp_erro, 4'(exp_cont), 2'b11});
    step(1);
    cls.fim_in = 1'b0;
    step(2);
    chk("manual_idle_busy", busy, 32'd0);

    // busy-time disturbance and early fim in GAP after the 3rd entry
    autoplay(2'd1, 3, 24'h7E5C3A, 14, 2'b10, 1'b1);
    // full-length phrase, last column forced terminal
    autoplay(2'd1, 6, 24'h7E5C3A, 29, 2'b11, 1'b0);

    // reset in GAP after the 2nd entry aborts silently
    b = cyc;
    modo = 1'b1; start = 1'b1; sel_frase = 2'd3;
    push(EV_RST, b + 1, 8'h00);
    push(EV_OK, b + 2, 8'h09);
    push(EV_OK, b + 7, 8'h0A);
    step(1);
    start = 1'b0;
    while (cyc < b + 9) step(1);
    reset = 1'b1;
    step(1);
    check_zero("reset_mid_gap");
    reset = 1'b0; exp_cont = 0; exp_erro = 1'b0;
    step(1);
    autoplay(2'd3, 3, 24'h0000A9, 13, 2'b01, 1'b0);

    // saturation of the result counter
    for (int i = 0; i < 16; i++) autoplay(2'd2, 2, 24'h000003, 8, 2'(i), 1'b0);
    chk("cont_saturated", cont_frases, 32'd15);

    step(3);
    chk("pending_events", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
